mc_ctrl_unit: RTL and testbench

Multicycle control FSM for the JCpu MIPS-subset core. It is the producer of the ALU's 4-bit aluc opcode and the consumer of the ALU's z (result zero) and v (signed overflow) flags. It decodes op/func from the instruction register and sequences IF/ID/EXE/MEM/WB. Each cycle it drives datapath mux selects and write enables, and it raises overflow and illegal-instruction exception pulses.

---
 rtl/mc_ctrl_unit.sv | 138 +++++++++++++
 tb/tb_mc_ctrl_unit.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/mc_ctrl_unit.sv
// mc_ctrl_unit: multicycle control FSM for the JCpu MIPS-subset core
module mc_ctrl_unit #(
    parameter logic RESET_PC_WR = 1'b0
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic [5:0] op,
    input  logic [5:0] func,
    input  logic       z,
    input  logic       v,
    output logic [3:0] aluc,
    output logic       pcwr,
    output logic       irwr,
    output logic       iord,
    output logic       wmem,
    output logic       wreg,
    output logic       m2reg,
    output logic       regrt,
    output logic       jal,
    output logic       sext,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic       ov_exc,
    output logic       ill_exc,
    output logic [2:0] state
);
    typedef enum logic [2:0] {
        S_IF  = 3'b000,
        S_ID  = 3'b001,
        S_EXE = 3'b010,
        S_MEM = 3'b011,
        S_WB  = 3'b100
    } state_e;

    state_e state_q, state_d;
    logic   ov_q, ill_q;

    logic rtype;
    logic r_add, r_sub, r_and, r_or, r_xor, r_sll, r_srl, r_sra, r_jr;
    logic i_addi, i_andi, i_ori, i_xori, i_lui, i_lw, i_sw, i_beq, i_bne, i_j, i_jal;
    logic legal, itype, branch, ovf_op, taken;
    logic in_if, in_id, in_exe, in_mem, in_wb;
    logic [3:0] aluc_exe;

    assign rtype  = op == 6'b000000;
    assign r_add  = rtype && func == 6'b100000;
    assign r_sub  = rtype && func == 6'b100010;
    assign r_and  = rtype && func == 6'b100100;
    assign r_or   = rtype && func == 6'b100101;
    assign r_xor  = rtype && func == 6'b100110;
    assign r_sll  = rtype && func == 6'b000000;
    assign r_srl  = rtype && func == 6'b000010;
    assign r_sra  = rtype && func == 6'b000011;
    assign r_jr   = rtype && func == 6'b001000;
    assign i_addi = op == 6'b001000;
    assign i_andi = op == 6'b001100;
    assign i_ori  = op == 6'b001101;
    assign i_xori = op == 6'b001110;
    assign i_lui  = op == 6'b001111;
    assign i_lw   = op == 6'b100011;
    assign i_sw   = op == 6'b101011;
    assign i_beq  = op == 6'b000100;
    assign i_bne  = op == 6'b000101;
    assign i_j    = op == 6'b000010;
    assign i_jal  = op == 6'b000011;

    assign itype  = i_addi | i_andi | i_ori | i_xori | i_lui | i_lw | i_sw | i_beq | i_bne;
    assign legal  = r_add | r_sub | r_and | r_or | r_xor | r_sll | r_srl | r_sra | r_jr
                  | itype | i_j | i_jal;
    assign branch = i_beq | i_bne;
    assign ovf_op = r_add | r_sub | i_addi;
    assign taken  = (i_beq & z) | (i_bne & ~z);

    assign in_if  = state_q == S_IF;
    assign in_id  = state_q == S_ID;
    assign in_exe = state_q == S_EXE;
    assign in_mem = state_q == S_MEM;
    assign in_wb  = state_q == S_WB;

    // ALU opcode selected by the instruction during execute
    always_comb begin
        aluc_exe = 4'b0000;
        if (r_sub | branch)        aluc_exe = 4'b0100;
        else if (r_and | i_andi)   aluc_exe = 4'b0001;
        else if (r_or | i_ori)     aluc_exe = 4'b0101;
        else if (r_xor | i_xori)   aluc_exe = 4'b0010;
        else if (i_lui)            aluc_exe = 4'b0110;
        else if (r_sll)            aluc_exe = 4'b0011;
        else if (r_srl)            aluc_exe = 4'b0111;
        else if (r_sra)            aluc_exe = 4'b1111;
    end

    // state sequencing; overflow in execute and illegal decode skip straight back to fetch
    always_comb begin
        state_d = S_IF;
        case (state_q)
            S_IF:    state_d = S_ID;
            S_ID:    state_d = (!legal || i_j || r_jr) ? S_IF : i_jal ? S_WB : S_EXE;
            S_EXE:   state_d = branch ? S_IF : (i_lw || i_sw) ? S_MEM : (ovf_op && v) ? S_IF : S_WB;
            S_MEM:   state_d = i_lw ? S_WB : S_IF;
            default: state_d = S_IF;
        endcase
    end

    // state register and one-cycle exception pulses, cleared asynchronously
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q <= S_IF;
            ov_q    <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ov_q    <= in_exe && ovf_op && v;
            ill_q   <= in_id && !legal;
        end
    end

    assign state   = state_q;
    assign ov_exc  = ov_q;
    assign ill_exc = ill_q;
    assign aluc    = in_exe ? aluc_exe : 4'b0000;
    assign pcwr    = !clrn ? RESET_PC_WR
                   : in_if | (in_id & (i_j | r_jr | i_jal)) | (in_exe & branch & taken);
    assign irwr    = clrn & in_if;
    assign iord    = in_mem;
    assign wmem    = clrn & in_mem & i_sw;
    assign wreg    = clrn & in_wb;
    assign m2reg   = in_wb & i_lw;
    assign regrt   = in_wb & itype;
    assign jal     = in_wb & i_jal;
    assign sext    = i_addi | i_lw | i_sw | branch;
    assign alusrca = in_exe;
    assign alusrcb = in_if ? 2'b01 : in_id ? 2'b11 : (in_exe && !rtype && !branch) ? 2'b10 : 2'b00;
    assign pcsrc   = (in_id && (i_j || i_jal)) ? 2'b11
                   : (in_id && r_jr) ? 2'b10
                   : (in_exe && branch && taken) ? 2'b01 : 2'b00;
endmodule

// File: tb/tb_mc_ctrl_unit.sv
// tb_mc_ctrl_unit: directed checks of the multicycle control FSM
module tb_mc_ctrl_unit;
    logic       clk = 1'b0;
    logic       clrn = 1'b0;
    logic [5:0] op = 6'b000000;
    logic [5:0] func = 6'b100000;
    logic       z = 1'b0;
    logic       v = 1'b0;
    logic [3:0] aluc;
    logic       pcwr, irwr, iord, wmem, wreg, m2reg, regrt, jal, sext, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic       ov_exc, ill_exc;
    logic [2:0] state;
    int         n_assert = 0;
    int         n_fail = 0;

    mc_ctrl_unit dut (
        .clk(clk), .clrn(clrn), .op(op), .func(func), .z(z), .v(v),
        .aluc(aluc), .pcwr(pcwr), .irwr(irwr), .iord(iord), .wmem(wmem),
        .wreg(wreg), .m2reg(m2reg), .regrt(regrt), .jal(jal), .sext(sext),
        .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc),
        .ov_exc(ov_exc), .ill_exc(ill_exc), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_state", state, 0);
        chk("rst_irwr", irwr, 0);
        chk("rst_pcwr", pcwr, 0);
        chk("rst_wreg", wreg, 0);
        chk("rst_exc", {ov_exc, ill_exc}, 0);
        clrn = 1'b1;
        #1;
        chk("add_if_state", state, 0);
        chk("add_if_ctl", {irwr, pcwr, iord, alusrcb, aluc}, {1'b1, 1'b1, 1'b0, 2'b01, 4'b0000});
        tick();
        chk("add_id_state", state, 1);
        chk("add_id_ctl", {pcwr, alusrcb, alusrca}, {1'b0, 2'b11, 1'b0});
        tick();
        chk("add_exe_state", state, 2);
        chk("add_exe_ctl", {aluc, alusrca, alusrcb, wreg}, {4'b0000, 1'b1, 2'b00, 1'b0});
        tick();
        chk("add_wb_state", state, 4);
        chk("add_wb_ctl", {wreg, regrt, m2reg}, {1'b1, 1'b0, 1'b0});
        tick();
        chk("add_done_state", state, 0);
        chk("add_done_wreg", wreg, 0);
        v = 1'b1;
        tick();
        tick();
        chk("ov_exe_state", state, 2);
        tick();
        chk("ov_after_state", state, 0);
        chk("ov_pulse", {ov_exc, ill_exc, wreg}, {1'b1, 1'b0, 1'b0});
        v = 1'b0;
        tick();
        chk("ov_clear", {state, ov_exc}, {3'd1, 1'b0});
        tick();
        chk("abort_exe_state", state, 2);
        #2 clrn = 1'b0;
        #1;
        chk("abort_state", state, 0);
        chk("abort_we", {wreg, wmem, irwr, ov_exc}, 0);
        @(negedge clk);
        clrn = 1'b1;
        #1;
        chk("abort_rel_state", state, 0);
        tick();
        chk("abort_rel_id", state, 1);
        tick();
        tick();
        tick();
        chk("abort_done_if", state, 0);
        op = 6'b000100;
        func = 6'b000000;
        tick();
        tick();
        z = 1'b1;
        #1;
        chk("beq_t", {pcwr, pcsrc, aluc, alusrcb, sext}, {1'b1, 2'b01, 4'b0100, 2'b00, 1'b1});
        z = 1'b0;
        #1;
        chk("beq_nt", pcwr, 0);
        tick();
        chk("beq_done", state, 0);
        op = 6'b000101;
        tick();
        tick();
        #1;
        chk("bne_t", {pcwr, pcsrc}, {1'b1, 2'b01});
        z = 1'b1;
        #1;
        chk("bne_nt", pcwr, 0);
        z = 1'b0;
        tick();
        op = 6'b100011;
        tick();
        tick();
        chk("lw_exe", {state, aluc, alusrcb, sext}, {3'd2, 4'b0000, 2'b10, 1'b1});
        tick();
        chk("lw_mem", {state, iord, wmem, wreg}, {3'd3, 1'b1, 1'b0, 1'b0});
        tick();
        chk("lw_wb", {state, m2reg, wreg, regrt}, {3'd4, 1'b1, 1'b1, 1'b1});
        tick();
        chk("lw_done", state, 0);
        op = 6'b101011;
        tick();
        tick();
        tick();
        chk("sw_mem", {state, iord, wmem, wreg}, {3'd3, 1'b1, 1'b1, 1'b0});
        tick();
        chk("sw_done", {state, wmem}, {3'd0, 1'b0});
        op = 6'b001101;
        tick();
        tick();
        chk("ori_exe", {aluc, sext, alusrcb}, {4'b0101, 1'b0, 2'b10});
        tick();
        tick();
        op = 6'b000000;
        func = 6'b000011;
        tick();
        tick();
        chk("sra_exe", {aluc, alusrcb}, {4'b1111, 2'b00});
        tick();
        tick();
        op = 6'b111111;
        tick();
        chk("ill_id", {state, pcwr, ill_exc}, {3'd1, 1'b0, 1'b0});
        tick();
        chk("ill_pulse", {state, ill_exc, ov_exc}, {3'd0, 1'b1, 1'b0});
        op = 6'b000011;
        tick();
        chk("jal_id", {state, pcwr, pcsrc, ill_exc}, {3'd1, 1'b1, 2'b11, 1'b0});
        tick();
        chk("jal_wb", {state, jal, wreg, regrt}, {3'd4, 1'b1, 1'b1, 1'b0});
        tick();
        chk("jal_done", state, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
